// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM states and the measurement constants
// for a 0x55 sync character at 16x oversampling.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_START,
        MEASURE,
        CALC,
        ERR
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SYNC_FALLS = 5;
    // Eight bit-times at 16x oversampling: count / (8 * 16) = count >> 7.
    localparam int MEAS_SHIFT = 7;
    localparam int ROUND_ADD  = 64;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times five falling edges of a 0x55 sync character and
// commits a 16x-oversampling divisor to the baud generator, holding it while busy.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int                    DVSR_WIDTH   = 8,
    parameter int                    CNT_WIDTH    = DVSR_WIDTH + 7,
    parameter logic [DVSR_WIDTH-1:0] DVSR_DEFAULT = 8'd26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx,
    output logic [DVSR_WIDTH-1:0] dvsr,
    output logic                  gen_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]            fall_cnt_q, fall_cnt_d;
    logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rx_d_q, rx_d_d;

    logic                  rx_sync;
    logic                  fall;
    logic                  cnt_max;
    logic                  last_fall;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [CNT_WIDTH:0]    round_sum;
    logic [CNT_WIDTH:0]    quot;
    logic                  quot_zero;
    logic [DVSR_WIDTH-1:0] new_dvsr;

    // Line idles high, so reset the RX path high to avoid a phantom falling edge.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_sync)
    );

    always_comb begin
        rx_d_d    = rx_sync;
        fall      = ~rx_sync & rx_d_q;
        cnt_max   = &cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        last_fall = fall && (fall_cnt_q == 3'(SYNC_FALLS - 1));
        // The division is evaluated on the edge-cycle count so the outcome
        // is registered on entry to CALC/ERR and visible in that state.
        round_sum = {1'b0, cnt_inc} + (CNT_WIDTH + 1)'(ROUND_ADD);
        quot      = round_sum >> MEAS_SHIFT;
        quot_zero = (quot == '0);
        new_dvsr  = DVSR_WIDTH'(quot - 1'b1);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        fall_cnt_d = fall_cnt_q;
        dvsr_d     = dvsr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                fall_cnt_d = '0;
                if (start) begin
                    state_d = WAIT_HIGH;
                    busy_d  = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (fall) begin
                    state_d    = MEASURE;
                    cnt_d      = '0;
                    fall_cnt_d = 3'd1;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                if (fall) fall_cnt_d = fall_cnt_q + 3'd1;
                // Saturation wins over a coincident last edge, keeping q <= 2^DVSR_WIDTH.
                if (cnt_max) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (last_fall) begin
                    busy_d = 1'b0;
                    if (quot_zero) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        done_d  = 1'b1;
                        dvsr_d  = new_dvsr;
                    end
                end
            end
            CALC: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fall_cnt_q <= '0;
            dvsr_q     <= DVSR_DEFAULT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_d_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fall_cnt_q <= fall_cnt_d;
            dvsr_q     <= dvsr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_d_q     <= rx_d_d;
        end
    end

    assign dvsr     = dvsr_q;
    assign busy     = busy_q;
    assign gen_hold = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud: each measurement pushes its expected
// outcome, and a monitor pops and compares on every done/err pulse.
module tb_uart_autobaud;

    localparam int DW = 8;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rx = 1'b1;
    logic [DW-1:0] dvsr;
    logic          gen_hold, busy, done, err;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] dvsr;
    } exp_t;

    exp_t          exp_q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            n_events = 0;
    logic [DW-1:0] model_dvsr = 8'd26;

    always #5 clk = ~clk;

    uart_autobaud #(
        .DVSR_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .DVSR_DEFAULT(8'd26)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rx      (rx),
        .dvsr    (dvsr),
        .gen_hold(gen_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic push_expect(input int bp);
        exp_t e;
        int   count, q;
        count = 8 * bp;
        q     = (count + 64) / 128;
        if (q == 0) begin
            e.is_err = 1'b1;
            e.dvsr   = model_dvsr;
        end else begin
            e.is_err   = 1'b0;
            e.dvsr     = 8'(q - 1);
            model_dvsr = e.dvsr;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.dvsr   = model_dvsr;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done || err) begin
                n_events++;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_result: got done=%0b err=%0b dvsr=%0d, want no pulse",
                             done, err, dvsr);
                end else begin
                    e = exp_q.pop_front();
                    if (done !== !e.is_err || err !== e.is_err || dvsr !== e.dvsr ||
                        busy !== 1'b0 || gen_hold !== 1'b0) begin
                        mismatched++;
                        $display("FAIL result: got done=%0b err=%0b dvsr=%0d busy=%0b hold=%0b, want done=%0b err=%0b dvsr=%0d busy=0 hold=0",
                                 done, err, dvsr, busy, gen_hold, !e.is_err, e.is_err, e.dvsr);
                    end
                end
                @(negedge clk);
                compared++;
                if (done !== 1'b0 || err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL pulse_width: got done=%0b err=%0b, want 0 0", done, err);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_frame(input int bp);
        logic [9:0] bits;
        bits = {1'b1, 8'h55, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (bp) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_result(input int seen, input int bound, input string name);
        int cycles = 0;
        while (n_events == seen && cycles < bound) begin
            @(posedge clk);
            cycles++;
        end
        if (n_events == seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no done/err within %0d cycles, want one", name, bound);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_idle(input string name, input logic [DW-1:0] want_dvsr);
        @(negedge clk);
        compared++;
        if (dvsr !== want_dvsr || busy !== 1'b0 || gen_hold !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: got dvsr=%0d busy=%0b hold=%0b done=%0b err=%0b, want dvsr=%0d all flags 0",
                     name, dvsr, busy, gen_hold, done, err, want_dvsr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pulse_start();
        repeat (3) @(posedge clk);
        check_idle("reset_values", 8'd26);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        check_idle("start_in_reset_ignored", 8'd26);
    endtask

    task automatic test_nominal();
        int seen = n_events;
        push_expect(434);
        pulse_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || gen_hold !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_after_start: got busy=%0b hold=%0b, want 1 1", busy, gen_hold);
        end
        send_frame(434);
        wait_result(seen, 500, "nominal");
    endtask

    task automatic test_exact();
        int seen = n_events;
        push_expect(160);
        pulse_start();
        send_frame(160);
        wait_result(seen, 200, "exact_160");
        seen = n_events;
        push_expect(320);
        pulse_start();
        send_frame(320);
        wait_result(seen, 400, "exact_320");
    endtask

    task automatic test_too_fast();
        int seen = n_events;
        push_expect(4);
        pulse_start();
        send_frame(4);
        wait_result(seen, 50, "too_fast");
        check_idle("too_fast_keeps_dvsr", model_dvsr);
    endtask

    task automatic test_timeout();
        int seen = n_events;
        push_err();
        pulse_start();
        repeat (5) @(posedge clk);
        #1 rx = 1'b0;
        wait_result(seen, 34000, "timeout");
        #1 rx = 1'b1;
        repeat (10) @(posedge clk);
        check_idle("timeout_keeps_dvsr", model_dvsr);
    endtask

    task automatic test_busy_start();
        int seen = n_events;
        push_expect(200);
        pulse_start();
        fork
            send_frame(200);
            begin
                repeat (500) @(posedge clk);
                pulse_start();
            end
        join
        wait_result(seen, 300, "busy_start");
        repeat (20) @(posedge clk);
        check_idle("busy_start_ignored", model_dvsr);
    endtask

    task automatic test_rx_low_start();
        int seen = n_events;
        @(posedge clk);
        #1 rx = 1'b0;
        pulse_start();
        repeat (60) @(posedge clk);
        @(negedge clk);
        compared++;
        if (n_events != seen || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rx_low_wait: got events=%0d busy=%0b, want events=%0d busy=1",
                     n_events, busy, seen);
        end
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        push_expect(100);
        send_frame(100);
        wait_result(seen, 200, "rx_low_start");
    endtask

    task automatic test_abort();
        int seen = n_events;
        pulse_start();
        fork
            send_frame(300);
            begin
                repeat (1000) @(posedge clk);
                #1 reset = 1'b0;
                repeat (3) @(posedge clk);
                check_idle("abort_reset_values", 8'd26);
                #1 reset = 1'b1;
            end
        join
        model_dvsr = 8'd26;
        repeat (50) @(posedge clk);
        @(negedge clk);
        compared++;
        if (n_events != seen || dvsr !== 8'd26) begin
            mismatched++;
            $display("FAIL abort_no_commit: got events=%0d dvsr=%0d, want events=%0d dvsr=26",
                     n_events, dvsr, seen);
        end
        seen = n_events;
        push_expect(434);
        pulse_start();
        send_frame(434);
        wait_result(seen, 500, "after_abort");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_nominal();
        test_exact();
        test_too_fast();
        test_timeout();
        test_busy_start();
        test_rx_low_start();
        test_abort();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d outstanding, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Auto-baud controller that configures the UART baud-rate generator's divisor.
- Measures a host-sent sync character 0x55 on the RX line and computes the divisor for 16x oversampling.
- Drives the generator's dvsr input, and holds the generator in reset while measuring.
- Sits between the RX pin synchroniser input and the baud generator, under control of the host/config logic.

Parameters:
- DVSR_WIDTH, 8: width of the divisor output; must match the baud generator.
- CNT_WIDTH, DVSR_WIDTH+7: width of the measurement counter, covering 8 bit-times at 16 ticks per bit.
- DVSR_DEFAULT, 8'd26: divisor loaded at reset and kept after a failed measurement.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; begins detection when IDLE, ignored otherwise
- rx  input  1  raw serial line, asynchronous
- dvsr  output  DVSR_WIDTH  divisor to the baud generator; registered
- gen_hold  output  1  high while busy; the generator is held in reset via this
- busy  output  1  high from the accepted start until done/err
- done  output  1  one-cycle pulse when a new dvsr is committed
- err  output  1  one-cycle pulse on timeout or out-of-range result

Behaviour:
- Clock and reset: single clock domain. When reset is sampled low at a clk edge:
  - dvsr = DVSR_DEFAULT
  - busy = gen_hold = done = err = 0
  - state = IDLE
  - counter and edge count cleared
  - This applies mid-measurement too; no partial result is ever committed.
- RX input path:
  - rx passes through a 2-flop synchroniser, then one more flop (rx_d) for edge detection.
  - A falling edge is sync==0 && rx_d==1.
  - The fixed 3-cycle input delay applies equally to every edge, so it does not bias the measurement.
- State machine:
  - IDLE: busy=0. On start -> WAIT_HIGH; busy and gen_hold go high on the next cycle.
  - WAIT_HIGH: wait for the synchronised rx==1 (line idle) -> WAIT_START. This prevents measuring from a mid-frame low.
  - WAIT_START: on a falling edge (start bit) -> MEASURE, with counter=0 and fall_cnt=1.
  - MEASURE:
    - Counter increments every cycle.
    - Each falling edge increments fall_cnt.
    - On the 5th falling edge (0x55 LSB-first gives falls at bit times 0, 2, 4, 6, 8), capture the counter value, which equals 8 bit-times in cycles -> CALC.
    - If the counter reaches all-ones before the 5th falling edge -> ERR (timeout).
  - CALC (1 cycle):
    - q = (count + 64) >> 7, computed in CNT_WIDTH+1 bits (round-to-nearest of count/128).
    - If q == 0 -> ERR.
    - Else dvsr <= q - 1, done=1 -> IDLE.
  - ERR (1 cycle): err=1, dvsr unchanged -> IDLE.
- Busy and hold timing:
  - busy and gen_hold deassert in the same cycle done or err pulses.
  - The generator restarts from count 0 with the new divisor.
- Latency: done is asserted 1 cycle after the cycle in which the 5th falling edge is detected.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle done/err is pulsing is ignored, because the state is not IDLE.
- Range:
  - q never exceeds 2^DVSR_WIDTH, because saturation is routed to ERR first. q-1 therefore always fits in DVSR_WIDTH.
- Rising edges are not counted. Glitch rejection beyond the synchroniser is out of scope.

Decomposition:
- Shared uart_pkg holds:
  - the state enum (IDLE, WAIT_HIGH, WAIT_START, MEASURE, CALC, ERR)
  - OVERSAMPLE=16
  - SYNC_FALLS=5
  - MEAS_SHIFT=7
  - ROUND_ADD=64
- One sub-module is natural: sync_2ff, the generic 1-bit synchroniser, reusable by the RX path.
- The counter and FSM stay in uart_autobaud.

Test Plan:
- Reset value: hold reset low 3 cycles -> dvsr=26, busy=gen_hold=done=err=0; start pulses during reset are ignored.
- Nominal: start, then 0x55 at 434 clk/bit (115200 baud @ 50 MHz) -> count=3472, done pulse, dvsr=26, busy/gen_hold drop in the done cycle.
- Exact divisor: 0x55 at 160 clk/bit -> count=1280, dvsr=9. Then a second start with 320 clk/bit -> dvsr=19.
- Too fast: 0x55 at 4 clk/bit -> q=0, err pulse, dvsr keeps its previous value, state returns to IDLE.
- Timeout: start, then rx held low indefinitely -> err after 2^15-1 counter cycles, dvsr unchanged.
- Abort and line state:
  - Reset asserted mid-MEASURE -> dvsr=DVSR_DEFAULT, no done.
  - Start while rx is low -> no measurement until rx returns high and falls again.
  - Start pulsed while busy -> no effect on the result.
